// File: rtl/system_top_bidir.sv
// system_top_bidir: one node of a two-board UART write link.
// Master side sends {A,ID},WRITE_DATA on the request UART and waits for a
// {C,*} byte on the response UART; slave side latches a peer's data byte onto
// leds and answers with {C,ID}.
// Optional feature macro: SYSTOP_RESP_TIMEOUT_EN (master response timeout).
`timescale 1ns/1ps

// 8N1 transmitter, LSB first, idle high; done pulses once after the stop bit.
module systop_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       line,
    output logic       done
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);

    logic          busy;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [8:0]    shreg;

    // Shift out start, 8 data bits and stop, one bit per CLKS_PER_BIT clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line    <= 1'b1;
            done    <= 1'b0;
            busy    <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '1;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy    <= 1'b1;
                    line    <= 1'b0;
                    shreg   <= {1'b1, data};
                    cnt     <= '0;
                    bit_idx <= '0;
                end
            end else if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                cnt <= '0;
                if (bit_idx == 4'd9) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    line    <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                    bit_idx <= bit_idx + 4'd1;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// 8N1 receiver with input synchronizer; valid pulses for one clk per good byte.
module systop_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       line,
    output logic       valid,
    output logic [7:0] data
);
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned HALF = CLKS_PER_BIT / 2;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     state;
    logic          s1, s2, prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    // Synchronize the line, find the start edge, sample each bit at its centre.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RX_IDLE;
            s1      <= 1'b1;
            s2      <= 1'b1;
            prev    <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            valid   <= 1'b0;
            data    <= '0;
        end else begin
            s1    <= line;
            s2    <= s1;
            prev  <= s2;
            valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (prev && !s2) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == CW'(HALF - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                        cnt   <= '0;
                        shreg <= {s2, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (s2) begin
                            valid <= 1'b1;
                            data  <= shreg;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end
endmodule

module system_top_bidir #(
    parameter int unsigned BOARD_ID     = 0,
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter logic [7:0]  WRITE_DATA   = 8'hFF,
    parameter int unsigned TIMEOUT_CLKS = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_trigger,
    output logic       uart_tx_req,
    input  logic       uart_rx_resp,
    input  logic       uart_rx_req,
    output logic       uart_tx_resp,
    output logic [7:0] leds
);
    localparam logic [3:0] ID        = 4'(BOARD_ID);
    localparam logic [7:0] HDR_BYTE  = {4'hA, ID};
    localparam logic [7:0] RESP_BYTE = {4'hC, ID};

    typedef enum logic [1:0] {M_IDLE, M_SEND_HDR, M_SEND_DATA, M_WAIT_RESP} m_state_t;
    typedef enum logic [1:0] {S_WAIT_HDR, S_WAIT_DATA, S_SEND_RESP} s_state_t;

    m_state_t   m_state;
    s_state_t   s_state;
    logic       t1, t2, t_prev;
    logic       trig_edge;
    logic       req_start, req_done;
    logic [7:0] req_tx_data;
    logic       resp_start, resp_done;
    logic       resp_valid, req_valid;
    logic [7:0] resp_rx_data, req_rx_data;
`ifdef SYSTOP_RESP_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
    logic [TW-1:0] timer;
`endif

    // Button synchronizer and rising-edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1     <= 1'b0;
            t2     <= 1'b0;
            t_prev <= 1'b0;
        end else begin
            t1     <= btn_trigger;
            t2     <= t1;
            t_prev <= t2;
        end
    end

    assign trig_edge = t2 & ~t_prev;

    systop_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_req_tx (
        .clk(clk), .rst_n(rst_n), .start(req_start), .data(req_tx_data),
        .line(uart_tx_req), .done(req_done)
    );

    systop_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_resp_rx (
        .clk(clk), .rst_n(rst_n), .line(uart_rx_resp),
        .valid(resp_valid), .data(resp_rx_data)
    );

    systop_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_req_rx (
        .clk(clk), .rst_n(rst_n), .line(uart_rx_req),
        .valid(req_valid), .data(req_rx_data)
    );

    systop_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_resp_tx (
        .clk(clk), .rst_n(rst_n), .start(resp_start), .data(RESP_BYTE),
        .line(uart_tx_resp), .done(resp_done)
    );

    // Master: send header then data, then wait for any {C,*} response byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state     <= M_IDLE;
            req_start   <= 1'b0;
            req_tx_data <= '0;
`ifdef SYSTOP_RESP_TIMEOUT_EN
            timer       <= '0;
`endif
        end else begin
            req_start <= 1'b0;
            case (m_state)
                M_IDLE: begin
                    if (trig_edge) begin
                        req_start   <= 1'b1;
                        req_tx_data <= HDR_BYTE;
                        m_state     <= M_SEND_HDR;
                    end
                end
                M_SEND_HDR: begin
                    if (req_done) begin
                        req_start   <= 1'b1;
                        req_tx_data <= WRITE_DATA;
                        m_state     <= M_SEND_DATA;
                    end
                end
                M_SEND_DATA: begin
                    if (req_done) begin
                        m_state <= M_WAIT_RESP;
`ifdef SYSTOP_RESP_TIMEOUT_EN
                        timer   <= '0;
`endif
                    end
                end
                M_WAIT_RESP: begin
                    if (resp_valid && ((resp_rx_data & 8'hF0) == 8'hC0)) begin
                        m_state <= M_IDLE;
`ifdef SYSTOP_RESP_TIMEOUT_EN
                    end else if (timer == TW'(TIMEOUT_CLKS - 1)) begin
                        m_state <= M_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
`endif
                    end
                end
                default: m_state <= M_IDLE;
            endcase
        end
    end

    // Slave: accept a foreign header, latch the data byte onto leds, respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_state    <= S_WAIT_HDR;
            resp_start <= 1'b0;
            leds       <= 8'h00;
        end else begin
            resp_start <= 1'b0;
            case (s_state)
                S_WAIT_HDR: begin
                    if (req_valid && (req_rx_data[7:4] == 4'hA) && (req_rx_data[3:0] != ID)) begin
                        s_state <= S_WAIT_DATA;
                    end
                end
                S_WAIT_DATA: begin
                    if (req_valid) begin
                        leds       <= req_rx_data;
                        resp_start <= 1'b1;
                        s_state    <= S_SEND_RESP;
                    end
                end
                S_SEND_RESP: begin
                    if (resp_done) begin
                        s_state <= S_WAIT_HDR;
                    end
                end
                default: s_state <= S_WAIT_HDR;
            endcase
        end
    end
endmodule

// File: tb/tb_system_top_bidir.sv
// Two cross-wired nodes (IDs 0 and 1) with randomized trigger timing; a serial
// monitor per line decodes bytes and checks them against expected queues.
`timescale 1ns/1ps

module tb_system_top_bidir;
    localparam int unsigned CPB  = 16;
    localparam int unsigned TOUT = 2000;
    localparam logic [7:0]  WD_A = 8'hFF;
    localparam logic [7:0]  WD_B = 8'h3C;

    logic       clk = 1'b0;
    logic       rst_a = 1'b0, rst_b = 1'b0;
    logic       btn_a = 1'b0, btn_b = 1'b0;
    logic       loop = 1'b0;
    logic       tx_req_a, tx_resp_a, tx_req_b, tx_resp_b;
    logic       rx_req_a, rx_req_b;
    logic [7:0] leds_a, leds_b;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q [4][$];
    bit         busy [2];
    logic [7:0] leds_m [2];
    logic [7:0] wd [2];

    always #10 clk = ~clk;

    assign rx_req_a = loop ? tx_req_a : tx_req_b;
    assign rx_req_b = loop ? 1'b1 : tx_req_a;

    system_top_bidir #(.BOARD_ID(0), .CLKS_PER_BIT(CPB), .WRITE_DATA(WD_A), .TIMEOUT_CLKS(TOUT)) u_a (
        .clk(clk), .rst_n(rst_a), .btn_trigger(btn_a), .uart_tx_req(tx_req_a),
        .uart_rx_resp(tx_resp_b), .uart_rx_req(rx_req_a), .uart_tx_resp(tx_resp_a), .leds(leds_a)
    );

    system_top_bidir #(.BOARD_ID(1), .CLKS_PER_BIT(CPB), .WRITE_DATA(WD_B), .TIMEOUT_CLKS(TOUT)) u_b (
        .clk(clk), .rst_n(rst_b), .btn_trigger(btn_b), .uart_tx_req(tx_req_b),
        .uart_rx_resp(tx_resp_a), .uart_rx_req(rx_req_b), .uart_tx_resp(tx_resp_b), .leds(leds_b)
    );

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic line_val(input int li);
        case (li)
            0:       return tx_req_a;
            1:       return tx_resp_a;
            2:       return tx_req_b;
            default: return tx_resp_b;
        endcase
    endfunction

    // Passive UART decoder for line li (0 req_a, 1 resp_a, 2 req_b, 3 resp_b).
    task automatic mon(input int li);
        logic [7:0] b;
        logic       stop_bit;
        forever begin
            @(negedge clk);
            if (line_val(li) == 1'b0) begin
                repeat (CPB / 2 - 1) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = line_val(li);
                end
                repeat (CPB) @(negedge clk);
                stop_bit = line_val(li);
                check8($sformatf("stop_bit_line%0d", li), {7'd0, stop_bit}, 8'h01);
                if (exp_q[li].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte_line%0d actual=%h required=none", li, b);
                end else begin
                    check8($sformatf("byte_line%0d", li), b, exp_q[li].pop_front());
                end
                if (li == 3) busy[0] = 1'b0;
                if (li == 1) busy[1] = 1'b0;
            end
        end
    endtask

    // Expected result of a trigger on node n, from the protocol rules.
    task automatic model_trigger(input int n, input bit peer_ok);
        int p;
        p = 1 - n;
        if (!busy[n]) begin
            busy[n] = 1'b1;
            exp_q[n * 2].push_back({4'hA, 4'(n)});
            exp_q[n * 2].push_back(wd[n]);
            if (peer_ok) begin
                leds_m[p] = wd[n];
                exp_q[p * 2 + 1].push_back({4'hC, 4'(p)});
            end
        end
    endtask

    task automatic pulse(input bit a, input bit b);
        @(negedge clk);
        #3;
        btn_a = a;
        btn_b = b;
        repeat ($urandom_range(3, 8)) @(negedge clk);
        btn_a = 1'b0;
        btn_b = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size());
        end
        repeat (10 + $urandom_range(0, 50)) @(negedge clk);
    endtask

    task automatic model_reset();
        busy[0] = 1'b0;
        busy[1] = 1'b0;
        leds_m[0] = 8'h00;
        leds_m[1] = 8'h00;
    endtask

    task automatic check_leds(input string tag);
        check8({tag, "_leds_a"}, leds_a, leds_m[0]);
        check8({tag, "_leds_b"}, leds_b, leds_m[1]);
    endtask

    initial begin
        int sel;
        wd[0] = WD_A;
        wd[1] = WD_B;
        model_reset();
        fork
            mon(0);
            mon(1);
            mon(2);
            mon(3);
        join_none

        // Reset state.
        repeat (5) @(negedge clk);
        check8("rst_tx_req_a", {7'd0, tx_req_a}, 8'h01);
        check8("rst_tx_resp_a", {7'd0, tx_resp_a}, 8'h01);
        check8("rst_tx_req_b", {7'd0, tx_req_b}, 8'h01);
        check8("rst_tx_resp_b", {7'd0, tx_resp_b}, 8'h01);
        check_leds("rst");
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (5) @(negedge clk);
        check_leds("post_rst");

        // A writes B, then B writes A, then both at once.
        model_trigger(0, 1'b1);
        pulse(1'b1, 1'b0);
        wait_drain(3000);
        check_leds("a_to_b");
        model_trigger(1, 1'b1);
        pulse(1'b0, 1'b1);
        wait_drain(3000);
        check_leds("b_to_a");
        model_trigger(0, 1'b1);
        model_trigger(1, 1'b1);
        pulse(1'b1, 1'b1);
        wait_drain(3000);
        check_leds("both");

        // Random sequence, sometimes re-triggering a busy master.
        for (int it = 0; it < 10; it++) begin
            sel = $urandom_range(0, 2);
            if (sel != 1) model_trigger(0, 1'b1);
            if (sel != 0) model_trigger(1, 1'b1);
            pulse(sel != 1, sel != 0);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(20, 200)) @(negedge clk);
                sel = (sel == 1) ? 1 : 0;
                model_trigger(sel, 1'b1);
                pulse(sel == 0, sel == 1);
            end
            wait_drain(3000);
            check_leds($sformatf("rand%0d", it));
        end

        // Loopback: A hears its own header and must reject it.
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        loop = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (5) @(negedge clk);
        model_trigger(0, 1'b0);
        pulse(1'b1, 1'b0);
        wait_drain(3000);
        repeat (300) @(negedge clk);
        check_leds("loopback");

        // B held in reset: A gets no response.
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        loop = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        repeat (5) @(negedge clk);
        model_trigger(0, 1'b0);
        pulse(1'b1, 1'b0);
        wait_drain(3000);
        check8("noresp_tx_resp_b", {7'd0, tx_resp_b}, 8'h01);
        repeat (TOUT + 200) @(negedge clk);
`ifdef SYSTOP_RESP_TIMEOUT_EN
        busy[0] = 1'b0;
`endif
        model_trigger(0, 1'b0);
        pulse(1'b1, 1'b0);
        wait_drain(3000);
        repeat (500) @(negedge clk);
        check_leds("noresp");
        for (int li = 0; li < 4; li++) begin
            check8($sformatf("leftover_line%0d", li), 8'(exp_q[li].size()), 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/system_top_bidir.md
# system_top_bidir

Board-level top for one node of a two-board link. A button press makes the node act as master: it sends a two-byte write request over a dedicated request UART, and the peer answers on a dedicated response UART. Each node also serves requests from its peer, latching the written byte onto its own LEDs. Two instances, cross-wired request-to-request and response-to-response, form a full bidirectional pair.

## Interface
- BOARD_ID, 0: node identity (low 4 bits used), carried in request and response bytes.
- CLKS_PER_BIT, 217: clocks per UART bit (50 MHz / 230400 baud).
- WRITE_DATA, 8'hFF: byte this node writes to the peer's LEDs on each trigger.
- TIMEOUT_CLKS, 50000: master response timeout (used only with the configuration macro).
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset (board reset button).
- btn_trigger  in  1  asynchronous; rising edge starts a master write.
- uart_tx_req  out  1  request UART TX to peer (8N1, idle high).
- uart_rx_resp  in  1  response UART RX from peer.
- uart_rx_req  in  1  request UART RX from peer.
- uart_tx_resp  out  1  response UART TX to peer.
- leds  out  8  local LED register.

## Operation
- Reset: leds=8'h00, uart_tx_req=1, uart_tx_resp=1, all FSMs idle, synchronizers preset (rx lines to 1, trigger to 0).
- UART: 8N1, LSB first. RX inputs and btn_trigger pass through 2-flop synchronizers. RX detects a falling edge, re-checks start bit at mid-bit, samples data at bit centres; a stop bit sampled 0 discards the byte.
- Request frame: byte0 = {4'hA, BOARD_ID[3:0]} of sender, byte1 = data.
- Response byte: {4'hC, BOARD_ID[3:0]} of responder.
- Master FSM: IDLE -> SEND_HDR -> SEND_DATA -> WAIT_RESP -> IDLE. Trigger rising edge in IDLE starts a request with data WRITE_DATA. WAIT_RESP exits on any received byte with upper nibble 4'hC; other bytes are ignored. Trigger edges outside IDLE are ignored (not queued).
- Slave FSM: WAIT_HDR -> WAIT_DATA -> SEND_RESP -> WAIT_HDR. A header byte needs upper nibble 4'hA and sender ID != own BOARD_ID[3:0]; otherwise discard and stay in WAIT_HDR. In WAIT_DATA the next valid byte is written to leds, then the response is sent.
- Master and slave run independently; simultaneous requests in both directions are fully concurrent on separate wires.
- Repeated writes of the same value leave leds unchanged but still produce a response.

## Timing
- Trigger rising edge to uart_tx_req start bit: at most 4 clk.
- Byte time: 10*CLKS_PER_BIT clk (2170 clk by default).
- leds update 1 clk after the stop-bit mid-sample of byte1; response start bit at most 2 clk later.
- Full transaction at defaults: about 3 byte times plus sync delays, under 7000 clk (140 us).
- Asynchronous reset at any point aborts all activity: lines return high immediately and leds return to 00. A peer receiving a truncated byte discards it on a bad stop bit, or accepts it if framing happens to be valid.

## Configuration
- SYSTOP_RESP_TIMEOUT_EN defined: WAIT_RESP returns to IDLE after TIMEOUT_CLKS clk with no valid response, so a later trigger is serviced.
- Not defined: WAIT_RESP waits indefinitely for a response and TIMEOUT_CLKS is unused.

## Test plan
- Reset both nodes (IDs 0,1) -> leds_a=leds_b=00, all tx lines 1.
- 100 ns pulse on A's btn_trigger -> A sends bytes A0,FF; leds_b=FF within 300 us; B returns byte C1; A's master is back in IDLE.
- Then pulse B's trigger -> B sends A1,FF; leds_a=FF; A returns C0.
- Trigger both nodes in the same cycle -> both leds reach FF, no lost bytes.
- Loop A's uart_tx_req back into A's uart_rx_req -> header A0 rejected, leds_a stays 00, no response sent.
- With the macro defined, leave B held in reset and trigger A -> A returns to IDLE after TIMEOUT_CLKS, and a second trigger produces a new request. Without the macro, A stays in WAIT_RESP.
